// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode constants, the immediate-type enum
// and the operand bypass helper used by the decode/operand-fetch stage.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // x0 reads as zero. EX beats WB because it is the younger producer.
  // A load in EX has no data yet, so it is never a bypass source; the
  // hazard logic stalls instead. WB is bypassed because reg_file only
  // commits the write at the coming edge.
  function automatic logic [31:0] resolve_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic        ex_en,
    input logic        ex_load,
    input logic [4:0]  ex_addr,
    input logic [31:0] ex_data,
    input logic        wb_en,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data
  );
    if (rs == 5'd0)                             return 32'd0;
    else if (ex_en && !ex_load && ex_addr == rs) return ex_data;
    else if (wb_en && wb_addr == rs)             return wb_data;
    else                                         return rf_data;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: classifies an RV32I instruction by immediate format
// and produces the sign-extended 32-bit immediate (0 for formats without one).
// Ports:
//   i_instr    - instruction word
//   o_imm_type - immediate format (IMM_NONE for R-type and unknown opcodes)
//   o_imm      - sign-extended immediate
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_type_e   o_imm_type,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;
  assign w_opcode = i_instr[6:0];

  always_comb begin
    o_imm_type = IMM_NONE;
    unique case (w_opcode)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: o_imm_type = IMM_I;
      OPC_STORE:                     o_imm_type = IMM_S;
      OPC_BRANCH:                    o_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:            o_imm_type = IMM_U;
      OPC_JAL:                       o_imm_type = IMM_J;
      default:                       o_imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    o_imm = 32'd0;
    unique case (o_imm_type)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'd0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage. Splits the fetched instruction, drives the
// reg_file read addresses, resolves operands with EX/WB bypass, stalls on
// load-use hazards and registers an ID/EX payload behind valid/ready.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   if_valid/if_ready        - fetch-side handshake; if_instr, if_pc payload
//   rf_rd_addr1/2, rf_rd_data1/2 - reg_file read ports
//   wb_en/wb_addr/wb_data    - writeback bypass source
//   ex_fwd_en/addr/data, ex_is_load - EX bypass source / load-use detection
//   flush                    - kill held and incoming instruction
//   id_valid/id_ready        - execute-side handshake; id_* payload
//   stall_cycles             - saturating count of load-use stall cycles
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no payload held, id_valid=0
// ST_FULL  | payload held for execute, id_valid=1
module id_operand_stage
  import rv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic [4:0]       rf_rd_addr1,
  output logic [4:0]       rf_rd_addr2,
  input  logic [31:0]      rf_rd_data1,
  input  logic [31:0]      rf_rd_data2,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  input  logic             ex_fwd_en,
  input  logic [4:0]       ex_fwd_addr,
  input  logic [31:0]      ex_fwd_data,
  input  logic             ex_is_load,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_rs1_val,
  output logic [31:0]      id_rs2_val,
  output logic [31:0]      id_imm,
  output logic [4:0]       id_rd,
  output logic [6:0]       id_opcode,
  output logic [2:0]       id_funct3,
  output logic             id_funct7b5,
  output logic             id_rd_we,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e r_state, w_state_nxt;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  imm_type_e   w_imm_type;
  logic [31:0] w_imm;
  logic        w_use_rs1, w_use_rs2, w_rd_we;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic        w_hazard, w_transfer, w_load;

  assign w_opcode    = if_instr[6:0];
  assign w_rd        = if_instr[11:7];
  assign w_rs1       = if_instr[19:15];
  assign w_rs2       = if_instr[24:20];
  assign rf_rd_addr1 = w_rs1;
  assign rf_rd_addr2 = w_rs2;

  imm_gen u_imm_gen (
    .i_instr    (if_instr),
    .o_imm_type (w_imm_type),
    .o_imm      (w_imm)
  );

  // Register usage follows the immediate format; OP is the one R-type
  // opcode and carries no immediate, so it is named explicitly.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_rd_we   = 1'b0;
    unique case (w_imm_type)
      IMM_I: begin w_use_rs1 = 1'b1; w_rd_we = 1'b1; end
      IMM_S, IMM_B: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      IMM_U, IMM_J: w_rd_we = 1'b1;
      default: begin
        if (w_opcode == OPC_OP) begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_rd_we   = 1'b1;
        end
      end
    endcase
    if (w_rd == 5'd0) w_rd_we = 1'b0;
  end

  assign w_rs1_val = resolve_operand(w_rs1, rf_rd_data1, ex_fwd_en, ex_is_load,
                                     ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);
  assign w_rs2_val = resolve_operand(w_rs2, rf_rd_data2, ex_fwd_en, ex_is_load,
                                     ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);

  assign w_hazard = ex_fwd_en && ex_is_load && (ex_fwd_addr != 5'd0) &&
                    ((w_use_rs1 && ex_fwd_addr == w_rs1) ||
                     (w_use_rs2 && ex_fwd_addr == w_rs2));

  // During flush the offered instruction is swallowed regardless of hazard.
  assign if_ready   = flush || ((!id_valid || id_ready) && !w_hazard);
  assign w_transfer = if_valid && if_ready;
  assign w_load     = w_transfer && !flush;
  assign id_valid   = (r_state == ST_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)                      w_state_nxt = ST_EMPTY;
    else if (w_transfer)            w_state_nxt = ST_FULL;
    else if (id_ready && id_valid)  w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc       <= '0;
      id_rs1_val  <= '0;
      id_rs2_val  <= '0;
      id_imm      <= '0;
      id_rd       <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7b5 <= 1'b0;
      id_rd_we    <= 1'b0;
    end else if (w_load) begin
      id_pc       <= if_pc;
      id_rs1_val  <= w_rs1_val;
      id_rs2_val  <= w_rs2_val;
      id_imm      <= w_imm;
      id_rd       <= w_rd;
      id_opcode   <= w_opcode;
      id_funct3   <= if_instr[14:12];
      id_funct7b5 <= if_instr[30];
      id_rd_we    <= w_rd_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (if_valid && w_hazard && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic        we;
  } pl_t;

  localparam logic [31:0] RF1 = 32'hAAAA0001;
  localparam logic [31:0] RF2 = 32'hBBBB0002;
  localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD0  = 32'h002001B3; // add x3,x0,x2
  localparam logic [31:0] I_SW    = 32'h00112423; // sw x1,8(x2)
  localparam logic [31:0] I_LUI   = 32'h123450B7; // lui x1,0x12345

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_fwd_en, ex_is_load;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        flush;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_rd_we;
  logic [2:0]  stall_cycles;

  int total = 0;
  int bad   = 0;
  pl_t sb[$];

  always #5 clk = ~clk;

  id_operand_stage #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .ex_is_load(ex_is_load), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_rd_we(id_rd_we), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted ID/EX payload is matched against the scoreboard.
  always @(negedge clk) begin
    pl_t act, exp;
    if (!rst && id_valid && id_ready) begin
      act = '{id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_opcode,
              id_funct3, id_funct7b5, id_rd_we};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL payload_unexpected: got %h expected none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL payload pc=%h: got %h expected %h", exp.pc, act, exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_valid = 0; flush = 0;
    ex_fwd_en = 0; ex_is_load = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    rf_rd_data1 = RF1; rf_rd_data2 = RF2;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1; if_instr = ins; if_pc = pc;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; id_ready = 1; if_instr = 0; if_pc = 0;
    quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_stall", {29'd0, stall_cycles}, 0);
    rst = 0;

    // addi x5,x0,-1
    offer(I_ADDI, 32'h100);
    chk("addi_if_ready", {31'd0, if_ready}, 1);
    chk("addi_rf_addr1", {27'd0, rf_rd_addr1}, 0);
    chk("addi_rf_addr2", {27'd0, rf_rd_addr2}, 31);
    sb.push_back('{32'h100, 32'd0, RF2, 32'hFFFFFFFF, 5'd5, 7'h13, 3'd0, 1'b1, 1'b1});
    cyc(); quiet();
    @(negedge clk);
    chk("addi_id_valid", {31'd0, id_valid}, 1);
    cyc();

    // EX bypass on rs1, WB bypass on rs2
    rf_rd_data1 = 10; rf_rd_data2 = 20;
    ex_fwd_en = 1; ex_fwd_addr = 1; ex_fwd_data = 7;
    wb_en = 1; wb_addr = 2; wb_data = 9;
    offer(I_ADD, 32'h104);
    chk("fwd_if_ready", {31'd0, if_ready}, 1);
    sb.push_back('{32'h104, 32'd7, 32'd9, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1});
    cyc(); quiet();

    // EX wins over WB on same reg; x0 never forwarded
    ex_fwd_en = 1; ex_fwd_addr = 1; ex_fwd_data = 7;
    wb_en = 1; wb_addr = 1; wb_data = 9;
    offer(I_ADD, 32'h108);
    sb.push_back('{32'h108, 32'd7, RF2, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1});
    cyc(); quiet();
    ex_fwd_en = 1; ex_fwd_addr = 0; ex_fwd_data = 7;
    wb_en = 1; wb_addr = 2; wb_data = 9;
    offer(I_ADD0, 32'h10C);
    sb.push_back('{32'h10C, 32'd0, 32'd9, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1});
    cyc(); quiet();

    // load-use on rs1 for one cycle
    ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 1; ex_fwd_data = 32'hDEAD;
    offer(I_ADD, 32'h110);
    chk("lu_if_ready", {31'd0, if_ready}, 0);
    cyc();
    ex_fwd_en = 0; ex_is_load = 0;
    @(negedge clk);
    chk("lu_bubble", {31'd0, id_valid}, 0);
    chk("lu_stall1", {29'd0, stall_cycles}, 1);
    chk("lu_release", {31'd0, if_ready}, 1);
    sb.push_back('{32'h110, RF1, RF2, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1});
    cyc(); quiet();

    // store stalls on load to its rs1 (x2)
    ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 2;
    offer(I_SW, 32'h114);
    chk("sw_if_ready", {31'd0, if_ready}, 0);
    cyc();
    ex_fwd_en = 0; ex_is_load = 0;
    @(negedge clk);
    chk("sw_stall2", {29'd0, stall_cycles}, 2);
    sb.push_back('{32'h114, RF1, RF2, 32'd8, 5'd8, 7'h23, 3'd2, 1'b0, 1'b0});
    cyc(); quiet();

    // lui with load to its rd field does not stall
    ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 1;
    offer(I_LUI, 32'h118);
    chk("lui_if_ready", {31'd0, if_ready}, 1);
    sb.push_back('{32'h118, RF1, RF2, 32'h12345000, 5'd1, 7'h37, 3'd5, 1'b0, 1'b1});
    cyc(); quiet();
    ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 8; // lui rs1 field, unused
    @(negedge clk);
    chk("lui_unused_rs", {31'd0, if_ready}, 1);
    cyc(); quiet();

    // backpressure
    id_ready = 0;
    offer(I_ADDI, 32'h200);
    chk("bp_accept", {31'd0, if_ready}, 1);
    sb.push_back('{32'h200, 32'd0, RF2, 32'hFFFFFFFF, 5'd5, 7'h13, 3'd0, 1'b1, 1'b1});
    cyc();
    for (int i = 0; i < 3; i++) begin
      offer(I_ADD, 32'h204);
      chk("bp_if_ready", {31'd0, if_ready}, 0);
      chk("bp_pc_hold", id_pc, 32'h200);
      chk("bp_imm_hold", id_imm, 32'hFFFFFFFF);
      cyc();
    end
    id_ready = 1;
    @(negedge clk);
    chk("bp_release", {31'd0, if_ready}, 1);
    sb.push_back('{32'h204, RF1, RF2, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1});
    cyc(); quiet();
    @(negedge clk);
    cyc();

    // flush while FULL with a hazardous instruction offered
    id_ready = 0;
    offer(I_ADDI, 32'h300);
    sb.push_back('{32'h300, 32'd0, RF2, 32'hFFFFFFFF, 5'd5, 7'h13, 3'd0, 1'b1, 1'b1});
    cyc();
    flush = 1; ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 1;
    offer(I_ADD, 32'h304);
    chk("fl_if_ready", {31'd0, if_ready}, 1);
    void'(sb.pop_back());
    cyc(); quiet();
    @(negedge clk);
    chk("fl_id_valid", {31'd0, id_valid}, 0);
    chk("fl_stall", {29'd0, stall_cycles}, 2);
    chk("fl_payload", id_pc, 32'h300);
    id_ready = 1;
    cyc();

    // counter saturation
    ex_fwd_en = 1; ex_is_load = 1; ex_fwd_addr = 1;
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h308;
    repeat (8) cyc();
    @(negedge clk);
    chk("sat_stall", {29'd0, stall_cycles}, 7);
    cyc(); quiet();

    // async reset while FULL
    id_ready = 0;
    offer(I_ADDI, 32'h400);
    sb.push_back('{32'h400, 32'd0, RF2, 32'hFFFFFFFF, 5'd5, 7'h13, 3'd0, 1'b1, 1'b1});
    cyc(); quiet();
    @(negedge clk);
    chk("ar_full", {31'd0, id_valid}, 1);
    rst = 1;
    #1;
    chk("ar_id_valid", {31'd0, id_valid}, 0);
    chk("ar_stall", {29'd0, stall_cycles}, 0);
    chk("ar_pc", id_pc, 0);
    void'(sb.pop_back());
    cyc();
    rst = 0; id_ready = 1;
    repeat (2) cyc();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
